// File: rtl/l2_miss_fill_ctrl.sv
// L2 miss/fill sequencer: one request at a time, tag lookup, fixed-latency L2 or DRAM
// service, tag fill on a miss, completion pulse, and saturating hit/miss statistics.
module l2_miss_fill_ctrl #(
   parameter int ADDR_W     = 32,
   parameter int LINE_LOG   = 6,
   parameter int L2_DELAY   = 20,
   parameter int DRAM_DELAY = 400
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   input  logic [ADDR_W-1:0] req_addr,
   output logic              req_ready,
   input  logic              abort,
   output logic [ADDR_W-1:0] lookup_addr,
   output logic              lookup_valid,
   input  logic              l2_hit,
   output logic              tag_write,
   output logic [ADDR_W-1:0] tag_write_addr,
   output logic              stall,
   output logic              resp_valid,
   output logic              resp_hit,
   output logic [ADDR_W-1:0] resp_addr,
   output logic [15:0]       hit_count,
   output logic [15:0]       miss_count
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOOKUP    = 3'd1,
      WAIT_L2   = 3'd2,
      WAIT_DRAM = 3'd3,
      FILL      = 3'd4,
      RESP      = 3'd5
   } state_t;

   localparam logic [9:0]        L2_LOAD   = 10'(L2_DELAY - 1);
   localparam logic [9:0]        DRAM_LOAD = 10'(DRAM_DELAY - 1);
   localparam logic [ADDR_W-1:0] LINE_MASK = ~((ADDR_W'(1) << LINE_LOG) - ADDR_W'(1));

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   state_t            state_q;
   logic [9:0]        cnt_q;
   logic [ADDR_W-1:0] addr_q;
   logic              hit_q;
   logic [15:0]       hit_cnt_q;
   logic [15:0]       miss_cnt_q;
   logic              req_ready_q;
   logic              stall_q;
   logic              lookup_valid_q;
   logic [ADDR_W-1:0] lookup_addr_q;
   logic              tag_write_q;
   logic [ADDR_W-1:0] tag_write_addr_q;
   logic              resp_valid_q;
   logic              resp_hit_q;
   logic [ADDR_W-1:0] resp_addr_q;

   // Sequencer state, service countdown, statistics and all registered outputs.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q          <= IDLE;
         cnt_q            <= 10'd0;
         addr_q           <= '0;
         hit_q            <= 1'b0;
         hit_cnt_q        <= 16'd0;
         miss_cnt_q       <= 16'd0;
         req_ready_q      <= 1'b1;
         stall_q          <= 1'b0;
         lookup_valid_q   <= 1'b0;
         lookup_addr_q    <= '0;
         tag_write_q      <= 1'b0;
         tag_write_addr_q <= '0;
         resp_valid_q     <= 1'b0;
         resp_hit_q       <= 1'b0;
         resp_addr_q      <= '0;
      end else begin
         // Strobes and their addresses are single-cycle; only the entering transition sets them.
         lookup_valid_q   <= 1'b0;
         lookup_addr_q    <= '0;
         tag_write_q      <= 1'b0;
         tag_write_addr_q <= '0;
         resp_valid_q     <= 1'b0;
         resp_hit_q       <= 1'b0;
         resp_addr_q      <= '0;
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  addr_q         <= req_addr;
                  state_q        <= LOOKUP;
                  lookup_valid_q <= 1'b1;
                  lookup_addr_q  <= req_addr;
                  stall_q        <= 1'b1;
                  req_ready_q    <= 1'b0;
               end else begin
                  stall_q     <= 1'b0;
                  req_ready_q <= 1'b1;
               end
            end
            LOOKUP: begin
               if (abort) begin
                  state_q     <= IDLE;
                  cnt_q       <= 10'd0;
                  stall_q     <= 1'b0;
                  req_ready_q <= 1'b1;
               end else if (l2_hit) begin
                  cnt_q     <= L2_LOAD;
                  hit_q     <= 1'b1;
                  hit_cnt_q <= sat_inc(hit_cnt_q);
                  state_q   <= WAIT_L2;
               end else begin
                  cnt_q      <= DRAM_LOAD;
                  hit_q      <= 1'b0;
                  miss_cnt_q <= sat_inc(miss_cnt_q);
                  state_q    <= WAIT_DRAM;
               end
            end
            WAIT_L2, WAIT_DRAM: begin
               if (abort) begin
                  state_q     <= IDLE;
                  cnt_q       <= 10'd0;
                  stall_q     <= 1'b0;
                  req_ready_q <= 1'b1;
               end else if (cnt_q != 10'd0) begin
                  cnt_q <= cnt_q - 10'd1;
               end else if (state_q == WAIT_L2) begin
                  state_q      <= RESP;
                  resp_valid_q <= 1'b1;
                  resp_hit_q   <= hit_q;
                  resp_addr_q  <= addr_q;
               end else begin
                  state_q          <= FILL;
                  tag_write_q      <= 1'b1;
                  tag_write_addr_q <= addr_q & LINE_MASK;
               end
            end
            FILL: begin
               state_q      <= RESP;
               resp_valid_q <= 1'b1;
               resp_hit_q   <= hit_q;
               resp_addr_q  <= addr_q;
            end
            RESP: begin
               state_q     <= IDLE;
               stall_q     <= 1'b0;
               req_ready_q <= 1'b1;
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= 10'd0;
               stall_q     <= 1'b0;
               req_ready_q <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready      = req_ready_q;
   assign stall          = stall_q;
   assign lookup_valid   = lookup_valid_q;
   assign lookup_addr    = lookup_addr_q;
   assign tag_write      = tag_write_q;
   assign tag_write_addr = tag_write_addr_q;
   assign resp_valid     = resp_valid_q;
   assign resp_hit       = resp_hit_q;
   assign resp_addr      = resp_addr_q;
   assign hit_count      = hit_cnt_q;
   assign miss_count     = miss_cnt_q;

endmodule

// File: tb/tb_l2_miss_fill_ctrl.sv
// Directed-vector bench for l2_miss_fill_ctrl with default delays (L2 20, DRAM 400).
// Cycle n means the n-th cycle after the accepting edge, sampled on the falling edge.
module tb_l2_miss_fill_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        req_ready;
   logic        abort;
   logic [31:0] lookup_addr;
   logic        lookup_valid;
   logic        l2_hit;
   logic        tag_write;
   logic [31:0] tag_write_addr;
   logic        stall;
   logic        resp_valid;
   logic        resp_hit;
   logic [31:0] resp_addr;
   logic [15:0] hit_count;
   logic [15:0] miss_count;

   int n_vec = 0;
   int n_err = 0;
   int tw_cnt = 0;
   int rv_cnt = 0;
   int stall_lo_cnt = 0;

   always #5 clk = ~clk;

   l2_miss_fill_ctrl dut (
      .clk            (clk),
      .reset          (reset),
      .req_valid      (req_valid),
      .req_addr       (req_addr),
      .req_ready      (req_ready),
      .abort          (abort),
      .lookup_addr    (lookup_addr),
      .lookup_valid   (lookup_valid),
      .l2_hit         (l2_hit),
      .tag_write      (tag_write),
      .tag_write_addr (tag_write_addr),
      .stall          (stall),
      .resp_valid     (resp_valid),
      .resp_hit       (resp_hit),
      .resp_addr      (resp_addr),
      .hit_count      (hit_count),
      .miss_count     (miss_count)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      tw_cnt       = 0;
      rv_cnt       = 0;
      stall_lo_cnt = 0;
   endtask

   task automatic adv(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         tw_cnt       += int'(tag_write);
         rv_cnt       += int'(resp_valid);
         stall_lo_cnt += int'(!stall);
      end
   endtask

   // Called on a falling edge in IDLE; returns on the falling edge of cycle 1 (LOOKUP).
   task automatic accept(input logic [31:0] a, input logic hit);
      req_valid = 1'b1;
      req_addr  = a;
      chk("accept_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      req_valid = 1'b0;
      l2_hit    = hit;
      clr();
      chk("lookup_valid", {31'd0, lookup_valid}, 32'd1);
      chk("lookup_addr", lookup_addr, a);
   endtask

   task automatic chk_reset_outs(input string p);
      chk({p, "_ready"}, {31'd0, req_ready}, 32'd1);
      chk({p, "_stall"}, {31'd0, stall}, 32'd0);
      chk({p, "_lkv"}, {31'd0, lookup_valid}, 32'd0);
      chk({p, "_lka"}, lookup_addr, 32'd0);
      chk({p, "_tw"}, {31'd0, tag_write}, 32'd0);
      chk({p, "_twa"}, tag_write_addr, 32'd0);
      chk({p, "_rv"}, {31'd0, resp_valid}, 32'd0);
      chk({p, "_rh"}, {31'd0, resp_hit}, 32'd0);
      chk({p, "_ra"}, resp_addr, 32'd0);
      chk({p, "_hits"}, {16'd0, hit_count}, 32'd0);
      chk({p, "_miss"}, {16'd0, miss_count}, 32'd0);
   endtask

   initial begin
      reset     = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'd0;
      abort     = 1'b0;
      l2_hit    = 1'b0;
      #1;
      chk_reset_outs("por");
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);

      // Hit: response in cycle 22, nothing before, no fill.
      accept(32'h0000_1040, 1'b1);
      adv(20);
      chk("hit_early_tw", tw_cnt, 0);
      chk("hit_early_rv", rv_cnt, 0);
      chk("hit_busy_stall", stall_lo_cnt, 0);
      adv(1);
      chk("hit_rv", {31'd0, resp_valid}, 32'd1);
      chk("hit_rh", {31'd0, resp_hit}, 32'd1);
      chk("hit_ra", resp_addr, 32'h0000_1040);
      chk("hit_cnt", {16'd0, hit_count}, 32'd1);
      chk("hit_miss_cnt", {16'd0, miss_count}, 32'd0);
      adv(1);
      chk("hit_rv_drop", {31'd0, resp_valid}, 32'd0);
      chk("hit_ra_zero", resp_addr, 32'd0);
      chk("hit_idle_stall", {31'd0, stall}, 32'd0);
      chk("hit_no_tw", tw_cnt, 0);

      // Miss: fill in cycle 402 with line-aligned address, response in 403.
      accept(32'h0ABC_D07F, 1'b0);
      adv(400);
      chk("miss_early_tw", tw_cnt, 0);
      chk("miss_early_rv", rv_cnt, 0);
      adv(1);
      chk("miss_tw", {31'd0, tag_write}, 32'd1);
      chk("miss_twa", tag_write_addr, 32'h0ABC_D040);
      chk("miss_rv_in_fill", {31'd0, resp_valid}, 32'd0);
      adv(1);
      chk("miss_rv", {31'd0, resp_valid}, 32'd1);
      chk("miss_rh", {31'd0, resp_hit}, 32'd0);
      chk("miss_ra", resp_addr, 32'h0ABC_D07F);
      chk("miss_tw_drop", {31'd0, tag_write}, 32'd0);
      chk("miss_twa_zero", tag_write_addr, 32'd0);
      chk("miss_cnt", {16'd0, miss_count}, 32'd1);
      adv(1);

      // Abort during DRAM wait at cycle 100: idle at 101, no completion ever.
      accept(32'h2000_0000, 1'b0);
      adv(99);
      abort = 1'b1;
      adv(1);
      abort = 1'b0;
      chk("abort_stall", {31'd0, stall}, 32'd0);
      chk("abort_ready", {31'd0, req_ready}, 32'd1);
      clr();
      adv(420);
      chk("abort_no_tw", tw_cnt, 0);
      chk("abort_no_rv", rv_cnt, 0);
      chk("abort_idle", stall_lo_cnt, 420);
      chk("abort_miss_cnt", {16'd0, miss_count}, 32'd2);

      // Abort in LOOKUP suppresses the hit increment.
      accept(32'h0000_3000, 1'b1);
      abort = 1'b1;
      adv(1);
      abort = 1'b0;
      chk("abl_stall", {31'd0, stall}, 32'd0);
      chk("abl_hit_cnt", {16'd0, hit_count}, 32'd1);
      adv(30);
      chk("abl_no_rv", rv_cnt, 0);

      // Normal request after aborts.
      accept(32'h0000_4444, 1'b1);
      adv(21);
      chk("post_abort_rv", {31'd0, resp_valid}, 32'd1);
      chk("post_abort_ra", resp_addr, 32'h0000_4444);
      chk("post_abort_hits", {16'd0, hit_count}, 32'd2);
      adv(1);

      // Abort in FILL is ignored.
      accept(32'h0000_9000, 1'b0);
      adv(401);
      abort = 1'b1;
      adv(1);
      abort = 1'b0;
      chk("fill_abort_rv", {31'd0, resp_valid}, 32'd1);
      chk("fill_abort_ra", resp_addr, 32'h0000_9000);
      adv(1);

      // Back-to-back with req_valid held: second accept right after the RESP-following IDLE.
      req_valid = 1'b1;
      req_addr  = 32'h0000_5000;
      l2_hit    = 1'b1;
      @(negedge clk);
      req_addr = 32'h0000_6000;
      clr();
      adv(20);
      chk("b2b_busy", stall_lo_cnt, 0);
      adv(1);
      chk("b2b_rv1", {31'd0, resp_valid}, 32'd1);
      chk("b2b_ra1", resp_addr, 32'h0000_5000);
      chk("b2b_resp_stall", {31'd0, stall}, 32'd1);
      adv(1);
      chk("b2b_idle_stall", {31'd0, stall}, 32'd0);
      chk("b2b_idle_lkv", {31'd0, lookup_valid}, 32'd0);
      adv(1);
      chk("b2b_accept2_stall", {31'd0, stall}, 32'd1);
      chk("b2b_lkv2", {31'd0, lookup_valid}, 32'd1);
      chk("b2b_lka2", lookup_addr, 32'h0000_6000);
      req_valid = 1'b0;
      adv(21);
      chk("b2b_rv2", {31'd0, resp_valid}, 32'd1);
      chk("b2b_ra2", resp_addr, 32'h0000_6000);
      chk("b2b_hits", {16'd0, hit_count}, 32'd4);
      adv(1);

      // Reset asserted at cycle 50 of a miss acts without a clock edge.
      accept(32'h7000_0040, 1'b0);
      adv(49);
      #1 reset = 1'b1;
      #1;
      chk_reset_outs("rst_mid");
      @(negedge clk);
      reset = 1'b0;
      clr();
      adv(450);
      chk("rst_mid_no_tw", tw_cnt, 0);
      chk("rst_mid_no_rv", rv_cnt, 0);
      chk("rst_mid_idle", stall_lo_cnt, 450);

      // Reset during FILL drops the fill strobe at once.
      accept(32'h8000_00FF, 1'b0);
      adv(401);
      chk("rst_fill_tw_pre", {31'd0, tag_write}, 32'd1);
      chk("rst_fill_twa_pre", tag_write_addr, 32'h8000_00C0);
      #1 reset = 1'b1;
      #1;
      chk("rst_fill_tw", {31'd0, tag_write}, 32'd0);
      chk("rst_fill_twa", tag_write_addr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clr();
      adv(10);
      chk("rst_fill_no_rv", rv_cnt, 0);
      chk("rst_fill_no_tw", tw_cnt, 0);

      // Saturation from a preloaded 0xFFFE.
      force dut.hit_cnt_q = 16'hFFFE;
      @(negedge clk);
      release dut.hit_cnt_q;
      @(negedge clk);
      chk("sat_preload", {16'd0, hit_count}, 32'h0000_FFFE);
      for (int k = 0; k < 3; k++) begin
         accept(32'h0000_A000 + 32'(k * 64), 1'b1);
         adv(21);
         chk("sat_rv", {31'd0, resp_valid}, 32'd1);
         chk("sat_hits", {16'd0, hit_count}, 32'h0000_FFFF);
         adv(1);
      end
      chk("sat_miss_cnt", {16'd0, miss_count}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
